// File: rtl/xain_pkg.sv
// Shared definitions for the ioctl streaming path.
//   streamer_state_t : state encoding of ioctl_streamer (IDLE must stay 0 so
//                      the reset value of the debug state port reads as 0)
//   IOCTL_ADDR_W     : byte address width on the ioctl bus
//   IOCTL_INDEX_W    : download slot index width
//   WORD_DATA_W      : host word width
//   WORD_W           : buffered entry width, {address, data}
//   word_byte()      : big-endian byte select, index 0 = bits [31:24]
package xain_pkg;

    localparam int IOCTL_ADDR_W  = 25;
    localparam int IOCTL_INDEX_W = 16;
    localparam int WORD_DATA_W   = 32;
    localparam int WORD_W        = IOCTL_ADDR_W + WORD_DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACTIVE = 3'd1,
        ST_EMIT   = 3'd2,
        ST_GAP    = 3'd3,
        ST_DRAIN  = 3'd4
    } streamer_state_t;

    function automatic logic [7:0] word_byte(input logic [WORD_DATA_W-1:0] w,
                                             input logic [1:0]             idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ioctl_word_fifo.sv
// Small synchronous FIFO holding host words ({address, data}) for the
// streamer. The head entry is presented from a register so the consumer
// sees a clean, flop-driven word.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write one entry (caller must not push while full
//                    unless it also pops in the same cycle)
//   i_pop          : drop the head entry (ignored while empty)
//   o_full/o_empty : occupancy flags
//   o_head         : registered copy of the oldest entry
//   o_count        : current occupancy
module ioctl_word_fifo #(
    parameter int WIDTH = 57,
    parameter int DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [PW-1:0]    w_rd_nxt;
    logic [CW-1:0]    w_count_nxt;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    // Full + push is accepted only when the head leaves in the same cycle.
    assign w_push      = i_push && (!w_full || i_pop);
    assign w_pop       = i_pop && !w_empty;
    assign w_rd_nxt    = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            // The incoming word bypasses the array when it lands in the head slot.
            if (w_count_nxt == '0) begin
                r_head <= '0;
            end else if (w_push && (w_rd_nxt == r_wr_ptr)) begin
                r_head <= i_data;
            end else begin
                r_head <= r_mem[w_rd_nxt];
            end
        end
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/ioctl_streamer.sv
// Converts host 32-bit word writes into the byte-serial ioctl download bus
// used by rom_loader. Each word is split MSB-first into four byte strobes
// separated by WR_GAP idle cycles; bytes at or beyond the download length
// are dropped silently.
//   clk, reset_n            : clock, asynchronous active-low reset
//   dl_start/dl_end         : download open / host-finished pulses
//   dl_index, dl_length     : slot index and byte count, latched on dl_start
//   wr_valid/wr_ready       : host word handshake
//   wr_addr, wr_data        : word byte address and big-endian data
//   ioctl_download/_index   : download in progress / latched slot index
//   ioctl_wr/_addr/_data    : byte strobe with its address and data
//   ioctl_wait              : consumer back-pressure
//   o_dbg_state             : current FSM state
//
// Handshake: a word transfers on a rising clk edge where wr_valid and
// wr_ready are both high; wr_valid may be held, and wr_addr/wr_data must
// stay stable until that edge.
module ioctl_streamer
    import xain_pkg::*;
#(
    parameter int WR_GAP     = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     dl_start,
    input  logic                     dl_end,
    input  logic [IOCTL_INDEX_W-1:0] dl_index,
    input  logic [IOCTL_ADDR_W-1:0]  dl_length,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [IOCTL_ADDR_W-1:0]  wr_addr,
    input  logic [WORD_DATA_W-1:0]   wr_data,
    output logic                     ioctl_download,
    output logic [IOCTL_INDEX_W-1:0] ioctl_index,
    output logic                     ioctl_wr,
    output logic [IOCTL_ADDR_W-1:0]  ioctl_addr,
    output logic [7:0]               ioctl_data,
    input  logic                     ioctl_wait,
    output streamer_state_t          o_dbg_state
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int GW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
    // A WR_GAP of 0 still spends one cycle in GAP.
    localparam logic [GW-1:0] GAP_LAST = GW'((WR_GAP > 0) ? WR_GAP - 1 : 0);

    streamer_state_t          r_state, w_state_nxt;
    logic [1:0]               r_cnt, w_cnt_nxt;
    logic [GW-1:0]            r_gap, w_gap_nxt;
    logic                     r_end_seen, w_end_nxt;
    logic                     r_download, w_download_nxt;
    logic [IOCTL_INDEX_W-1:0] r_index;
    logic [IOCTL_ADDR_W-1:0]  r_length;
    logic                     r_wr, w_wr_nxt;
    logic [IOCTL_ADDR_W-1:0]  r_addr;
    logic [7:0]               r_data;
    logic                     r_wr_ready;

    logic                     w_push;
    logic                     w_pop;
    logic                     w_emit;
    logic                     w_full;
    logic                     w_empty;
    logic [WORD_W-1:0]        w_head;
    logic [CW-1:0]            w_count;
    logic [CW-1:0]            w_count_nxt;
    logic [IOCTL_ADDR_W-1:0]  w_byte_addr;
    logic                     w_suppress;
    logic                     w_more;
    logic                     w_unused;

    assign w_push = wr_valid && r_wr_ready;

    ioctl_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_push  (w_push),
        .i_data  ({wr_addr, wr_data}),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Word address low bits are replaced by the byte counter.
    assign w_unused    = ^w_head[WORD_DATA_W+1:WORD_DATA_W] ^ w_full;
    assign w_byte_addr = {w_head[WORD_W-1:WORD_DATA_W+2], r_cnt};
    assign w_suppress  = (w_byte_addr >= r_length);
    // Another word will be at the head after this pop, so skip ACTIVE and
    // keep the byte cadence unbroken across word boundaries.
    assign w_more      = (w_count > CW'(1)) || w_push;

    always_comb begin
        streamer_state_t adv_state;
        logic [1:0]      adv_cnt;
        logic            adv_pop;

        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_gap_nxt      = r_gap;
        w_end_nxt      = r_end_seen;
        w_download_nxt = r_download;
        w_wr_nxt       = 1'b0;
        w_emit         = 1'b0;
        w_pop          = 1'b0;

        // Step to the next byte, or retire the head word after byte 3.
        adv_pop = 1'b0;
        if (r_cnt != 2'd3) begin
            adv_state = ST_EMIT;
            adv_cnt   = r_cnt + 2'd1;
        end else begin
            adv_pop   = 1'b1;
            adv_cnt   = 2'd0;
            adv_state = w_more ? ST_EMIT : ST_ACTIVE;
        end

        if ((r_state != ST_IDLE) && dl_end) begin
            w_end_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (dl_start) begin
                    w_download_nxt = 1'b1;
                    w_state_nxt    = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!w_empty && !ioctl_wait) begin
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = ST_EMIT;
                end else if (w_empty && r_end_seen) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_EMIT: begin
                if (!w_suppress) begin
                    w_wr_nxt    = 1'b1;
                    w_emit      = 1'b1;
                    w_gap_nxt   = '0;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_state_nxt = adv_state;
                    w_cnt_nxt   = adv_cnt;
                    w_pop       = adv_pop;
                end
            end
            ST_GAP: begin
                if (r_gap != GAP_LAST) begin
                    w_gap_nxt = r_gap + 1'b1;
                end else if (!ioctl_wait) begin
                    w_state_nxt = adv_state;
                    w_cnt_nxt   = adv_cnt;
                    w_pop       = adv_pop;
                end
            end
            ST_DRAIN: begin
                if (!ioctl_wait) begin
                    w_download_nxt = 1'b0;
                    w_end_nxt      = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_gap      <= '0;
            r_end_seen <= 1'b0;
            r_download <= 1'b0;
            r_index    <= '0;
            r_length   <= '0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_wr_ready <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_gap      <= w_gap_nxt;
            r_end_seen <= w_end_nxt;
            r_download <= w_download_nxt;
            r_wr       <= w_wr_nxt;
            // wr_ready is registered, so it is computed from next-cycle state.
            r_wr_ready <= (w_count_nxt != CW'(FIFO_DEPTH)) && w_download_nxt && !w_end_nxt;
            if ((r_state == ST_IDLE) && dl_start) begin
                r_index  <= dl_index;
                r_length <= dl_length;
            end
            if (w_emit) begin
                r_addr <= w_byte_addr;
                r_data <= word_byte(w_head[WORD_DATA_W-1:0], r_cnt);
            end
        end
    end

    assign wr_ready       = r_wr_ready;
    assign ioctl_download = r_download;
    assign ioctl_index    = r_index;
    assign ioctl_wr       = r_wr;
    assign ioctl_addr     = r_addr;
    assign ioctl_data     = r_data;
    assign o_dbg_state    = r_state;

endmodule

// File: doc/ioctl_streamer.md
IOCTL_STREAMER -- requirements
Module: ioctl_streamer

Interface
REQ-001 Parameter WR_GAP, default 3: idle cycles forced after every ioctl_wr pulse, so rom_loader can cross into the SDRAM clock domain.
REQ-002 Parameter FIFO_DEPTH, default 2: number of 32-bit word entries in the input buffer.
REQ-003 clk  in  1  system clock; the single clock of the block.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 dl_start  in  1  one-cycle pulse that opens a download.
REQ-006 dl_end  in  1  one-cycle pulse; the host has sent all words.
REQ-007 dl_index  in  16  slot index, latched on dl_start.
REQ-008 dl_length  in  25  total byte count, latched on dl_start.
REQ-009 wr_valid  in  1  host word valid.
REQ-010 wr_ready  out  1  word accepted when wr_valid && wr_ready.
REQ-011 wr_addr  in  25  byte address of the word; bits [1:0] are ignored.
REQ-012 wr_data  in  32  big-endian word; [31:24] is the lowest address.
REQ-013 ioctl_download  out  1  download in progress.
REQ-014 ioctl_index  out  16  latched dl_index.
REQ-015 ioctl_wr  out  1  one-cycle byte strobe.
REQ-016 ioctl_addr  out  25  byte address, valid while ioctl_wr is high.
REQ-017 ioctl_data  out  8  byte data, valid while ioctl_wr is high.
REQ-018 ioctl_wait  in  1  consumer back-pressure.

Function
REQ-019 The FSM SHALL have the states IDLE, ACTIVE, EMIT, GAP and DRAIN.
REQ-020 IDLE: dl_start SHALL latch dl_index and dl_length, set ioctl_download on the next cycle, and go to ACTIVE.
REQ-021 dl_start SHALL be ignored in every state other than IDLE.
REQ-022 ACTIVE: when the FIFO is non-empty and ioctl_wait=0, the FSM SHALL go to EMIT with byte counter = 0.
REQ-023 ACTIVE: when the FIFO is empty and end_seen=1, the FSM SHALL go to DRAIN.
REQ-024 EMIT: ioctl_wr SHALL be high for exactly one cycle, with ioctl_addr = {head_addr[24:2], cnt} and ioctl_data = byte cnt of head_data, MSB-first. The FSM then goes to GAP.
REQ-025 A byte whose address is >= the latched dl_length SHALL be suppressed: no ioctl_wr pulse, no GAP, and it still counts as consumed.
REQ-026 GAP: the FSM SHALL count WR_GAP cycles, then wait while ioctl_wait=1.
REQ-027 On leaving GAP, the FSM SHALL increment cnt and return to EMIT; after cnt=3 it SHALL instead pop the FIFO head and return to ACTIVE.
REQ-028 Max throughput SHALL be 1 byte per (1+WR_GAP) cycles, with no extra bubble between words when the FIFO is non-empty.
REQ-029 dl_end SHALL set end_seen in any non-IDLE state; words already buffered SHALL still be emitted in full.
REQ-030 DRAIN: ioctl_download SHALL clear one cycle after entry, provided ioctl_wait=0; the FSM then goes to IDLE and clears end_seen.
REQ-031 wr_ready = (FIFO not full) && ioctl_download && !end_seen.
REQ-032 Push and pop in the same cycle with the FIFO full SHALL be legal: occupancy is unchanged and wr_ready stays low for that cycle.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-034 ioctl_addr arithmetic SHALL be 25-bit unsigned with no carry out of bit 24.
REQ-035 ioctl_addr and ioctl_data SHALL hold their last values when ioctl_wr is low.

Reset
REQ-036 With reset_n low, all outputs SHALL be forced to 0 asynchronously: ioctl_download, ioctl_wr, ioctl_addr, ioctl_data, ioctl_index, wr_ready.
REQ-037 With reset_n low, the FSM SHALL return to IDLE and the FIFO, cnt and end_seen SHALL clear.
REQ-038 Reset during EMIT SHALL truncate the ioctl_wr pulse; partial words are discarded.
REQ-039 Release of reset_n SHALL be synchronous to clk (external synchronizer); the first cycle after release SHALL be IDLE.

Structure
REQ-040 The FSM state enum (streamer_state_t) and the IOCTL_ADDR_W=25 and IOCTL_INDEX_W=16 constants SHALL live in xain_pkg.
REQ-041 The word buffer SHALL be one sub-module, ioctl_word_fifo, parameterised by width (57 bits: address plus data) and depth.
REQ-042 ioctl_word_fifo SHALL provide push, pop, full, empty and a registered head.
REQ-043 All outputs of the top level SHALL be registered.

Verification
REQ-044 dl_start (index 0, length 8), then words 0x000000:0x11223344 and 0x000004:0x55667788, then dl_end -> 8 ioctl_wr pulses, addr 0..7, data 11,22,33,44,55,66,77,88; pulse spacing 4 cycles; ioctl_download drops after the last GAP.
REQ-045 dl_length=6 with the same two words -> only 6 pulses (addr 0..5); bytes 77 and 88 are not emitted.
REQ-046 ioctl_wait held high for 10 cycles after byte 2 -> byte 3 is delayed until wait falls; no byte is lost or duplicated.
REQ-047 Host pushes 5 back-to-back words with FIFO_DEPTH=2 -> wr_ready low while full; all 20 bytes are emitted in order.
REQ-048 Assert reset_n=0 mid-EMIT of byte 5 -> all outputs 0 in the same cycle; after release, a new dl_start restarts from addr 0.
REQ-049 dl_start during ACTIVE, and dl_end while the FIFO holds 2 words -> dl_start is ignored with ioctl_index unchanged; the buffered 8 bytes are emitted before ioctl_download falls.
